rca_nibble_sequencer: RTL and testbench

//  Multi-cycle wide adder built around one shared 4-bit ripple-carry slice with carry-in.
//  Two requesters compete for the slice through a round-robin arbiter.
//  The winner's WIDTH-bit operands are added one nibble per clock, LSB first, through a carry register.

---
 rtl/rca_nibble_sequencer.sv | 149 ++++++++++++++
 tb/tb_rca_nibble_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_sequencer.sv
// Two-requester wide adder that time-shares one 4-bit ripple-carry slice, one nibble per clock.
// Optional subtract mode when RCA_SEQ_SUB_EN is defined (adds the req_sub port).
module rca_nibble_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef RCA_SEQ_SUB_EN
  input  logic [NREQ-1:0]       req_sub,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);

  localparam int unsigned NNIB = WIDTH / 4;
  localparam int unsigned IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              id_q, id_d;
  logic              valid_d, rid_d, cout_d;
  logic [WIDTH-1:0]  sum_d;

  logic              winner_c;
  logic              sub_c;
  logic [WIDTH-1:0]  sel_a_c, sel_b_c;
  logic [4:0]        slice_c;
  logic [WIDTH-1:0]  acc_nx_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      id_q      <= id_d;
      rsp_valid <= valid_d;
      rsp_id    <= rid_d;
      rsp_sum   <= sum_d;
      rsp_cout  <= cout_d;
    end
  end

  // Arbitration, nibble slice and next-state logic
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    id_d      = id_q;
    valid_d   = rsp_valid;
    rid_d     = rsp_id;
    sum_d     = rsp_sum;
    cout_d    = rsp_cout;
    req_ready = '0;

    winner_c = req_valid[rr_q] ? rr_q : ~rr_q;
`ifdef RCA_SEQ_SUB_EN
    sub_c    = req_sub[winner_c];
`else
    sub_c    = 1'b0;
`endif
    sel_a_c  = winner_c ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    sel_b_c  = winner_c ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    // Operands shift right one nibble per step; the sum fills in from the top.
    slice_c  = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(carry_q);
    acc_nx_c = WIDTH'({slice_c[3:0], acc_q} >> 4);

    case (state_q)
      IDLE: begin
        if (rst_n && (|req_valid)) begin
          req_ready[winner_c] = 1'b1;
          // Subtract is A + ~B + 1: invert B once here, seed the carry with 1.
          a_d     = sel_a_c;
          b_d     = sel_b_c ^ {WIDTH{sub_c}};
          carry_d = sub_c;
          id_d    = winner_c;
          idx_d   = '0;
          rr_d    = ~winner_c;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        acc_d   = acc_nx_c;
        carry_d = slice_c[4];
        if (idx_q == IDXW'(NNIB - 1)) begin
          idx_d   = '0;
          valid_d = 1'b1;
          rid_d   = id_q;
          sum_d   = acc_nx_c;
          cout_d  = slice_c[4];
          state_d = RESP;
        end else begin
          idx_d = IDXW'(idx_q + 1'b1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Self-checking bench for rca_nibble_sequencer (WIDTH=16); sub-mode checks enabled with RCA_SEQ_SUB_EN.
module tb_rca_nibble_sequencer;

  localparam int unsigned W    = 16;
  localparam int unsigned NNIB = W / 4;
`ifdef RCA_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_a, req_b;
`ifdef RCA_SEQ_SUB_EN
  logic [1:0]    req_sub;
`endif
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout;

  int vectors = 0;
  int miscompares = 0;

  rca_nibble_sequencer #(.WIDTH(W), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef RCA_SEQ_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request and waits for its response; leaves the response un-acknowledged.
  task automatic single_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] sum, output logic cout, output logic rid,
                           output int lat, output bit ok);
    int n;
    ok = 1'b0; lat = 0; sum = '0; cout = 1'b0; rid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin @(negedge clk); #1; n++; end
    if (!req_ready[id]) begin req_valid = '0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    req_a = $urandom;
    req_b = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!rsp_valid) return;
    sum = rsp_sum; cout = rsp_cout; rid = rsp_id; ok = 1'b1;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    req_a = $urandom; req_b = $urandom;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_fields: got sum=%h cout=%b id=%b expected 0", rsp_sum, rsp_cout, rsp_id);
    end
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic c, r; int lat; bit ok;
    single_op(0, 16'h0005, 16'h0003, s, c, r, lat, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic0_timeout: got no response expected one"); end
    vectors++; if (lat != NNIB) begin miscompares++; $display("FAIL basic0_latency: got %0d expected %0d", lat, NNIB); end
    vectors++; if (s !== 16'h0008 || c !== 1'b0 || r !== 1'b0) begin
      miscompares++; $display("FAIL basic0_result: got sum=%h cout=%b id=%b expected 0008/0/0", s, c, r);
    end
    ack_rsp();
    single_op(1, 16'hFFFF, 16'hFFFF, s, c, r, lat, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic1_timeout: got no response expected one"); end
    vectors++; if (lat != NNIB) begin miscompares++; $display("FAIL basic1_latency: got %0d expected %0d", lat, NNIB); end
    vectors++; if (s !== 16'hFFFE || c !== 1'b1 || r !== 1'b1) begin
      miscompares++; $display("FAIL basic1_result: got sum=%h cout=%b id=%b expected fffe/1/1", s, c, r);
    end
    ack_rsp();
  endtask

  task automatic test_arbitration();
    int exp_order[4] = '{0, 1, 0, 1};
    int grants = 0, done = 0, gcyc = 0;
    bit busy = 1'b0;
    logic eid;
    logic [W:0] esum;
    logic w;
    apply_reset();
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && done < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin req_valid = 2'b11; req_a = $urandom; req_b = $urandom; end
      #1;
      vectors++; if ($countones(req_ready) > 1) begin miscompares++; $display("FAIL arb_onehot: got %b expected at most one bit", req_ready); end
      if (busy) begin
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL arb_ready_busy: got %b expected 00", req_ready); end
        if (rsp_valid) begin
          vectors++; if (cyc - gcyc - 1 != NNIB) begin miscompares++; $display("FAIL arb_latency: got %0d expected %0d", cyc - gcyc - 1, NNIB); end
          vectors++; if ({rsp_id, rsp_cout, rsp_sum} !== {eid, esum}) begin
            miscompares++; $display("FAIL arb_result: got id=%b cout=%b sum=%h expected id=%b cout=%b sum=%h",
                                    rsp_id, rsp_cout, rsp_sum, eid, esum[W], esum[W-1:0]);
          end
          busy = 1'b0; done++;
        end
        req_a = $urandom; req_b = $urandom;
      end else if (req_ready != 2'b00) begin
        w = req_ready[1];
        vectors++; if (int'(w) != exp_order[grants]) begin miscompares++; $display("FAIL arb_order: grant %0d got %0d expected %0d", grants, w, exp_order[grants]); end
        eid  = w;
        esum = {1'b0, req_a[int'(w)*W +: W]} + {1'b0, req_b[int'(w)*W +: W]};
        gcyc = cyc; busy = 1'b1; grants++;
      end
    end
    vectors++; if (done < 4) begin miscompares++; $display("FAIL arb_timeout: got %0d responses expected 4", done); end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s, a, b; logic c, r; int lat; bit ok;
    logic [W:0] e;
    a = W'($urandom); b = W'($urandom);
    e = {1'b0, a} + {1'b0, b};
    single_op(1, a, b, s, c, r, lat, ok);
    vectors++; if (!ok || {r, c, s} !== {1'b1, e}) begin
      miscompares++; $display("FAIL bp_result: got ok=%b id=%b cout=%b sum=%h expected 1/1/%b/%h", ok, r, c, s, e[W], e[W-1:0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {2'b11, e}) begin
        miscompares++; $display("FAIL bp_hold%0d: got v=%b id=%b cout=%b sum=%h expected 1/1/%b/%h",
                                k, rsp_valid, rsp_id, rsp_cout, rsp_sum, e[W], e[W-1:0]);
      end
    end
    ack_rsp();
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got rsp_valid=%b expected 0", rsp_valid); end
    vectors++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b1, e}) begin
      miscompares++; $display("FAIL bp_keep: got id=%b cout=%b sum=%h expected 1/%b/%h", rsp_id, rsp_cout, rsp_sum, e[W], e[W-1:0]);
    end
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_idle: got req_ready=%b expected 01", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] s; logic c, r; int lat; bit ok; bit seen = 1'b0;
    @(negedge clk);
    req_valid = 2'b01; req_a[W-1:0] = 16'h1234; req_b[W-1:0] = 16'h1111;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL midrun_grant: got %b expected 01", req_ready); end
    @(posedge clk);
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if ({req_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum} !== '0) begin
      miscompares++; $display("FAIL midrun_reset: got rdy=%b v=%b id=%b cout=%b sum=%h expected all 0",
                              req_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    vectors++; if (seen) begin miscompares++; $display("FAIL midrun_dropped: got a response expected none"); end
    single_op(0, 16'h1234, 16'h1111, s, c, r, lat, ok);
    vectors++; if (!ok || lat != NNIB || {r, c, s} !== {2'b00, 16'h2345}) begin
      miscompares++; $display("FAIL midrun_after: got ok=%b lat=%0d id=%b cout=%b sum=%h expected 1/%0d/0/0/2345", ok, lat, r, c, s, NNIB);
    end
    ack_rsp();
  endtask

  task automatic test_random();
    int done = 0, gcyc = 0;
    bit busy = 1'b0, seen = 1'b0, rr = 1'b0, s = 1'b0;
    logic w, ew, eid;
    logic [W-1:0] a, b;
    logic [W:0] esum;
    apply_reset();
    for (int cyc = 0; cyc < 6000 && done < 150; cyc++) begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 99) < 60);
      if (busy) begin
        #1;
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rnd_ready_busy: got %b expected 00", req_ready); end
        if (rsp_valid) begin
          if (!seen) begin
            vectors++; if (cyc - gcyc - 1 != NNIB) begin miscompares++; $display("FAIL rnd_latency: got %0d expected %0d", cyc - gcyc - 1, NNIB); end
            seen = 1'b1;
          end
          vectors++; if ({rsp_id, rsp_cout, rsp_sum} !== {eid, esum}) begin
            miscompares++; $display("FAIL rnd_result: got id=%b cout=%b sum=%h expected id=%b cout=%b sum=%h",
                                    rsp_id, rsp_cout, rsp_sum, eid, esum[W], esum[W-1:0]);
          end
          if (rsp_ready) begin busy = 1'b0; done++; end
        end else if (seen) begin
          vectors++; miscompares++; $display("FAIL rnd_valid_drop: got rsp_valid=0 expected 1 before handshake");
        end
        req_valid = 2'($urandom); req_a = $urandom; req_b = $urandom;
`ifdef RCA_SEQ_SUB_EN
        req_sub = 2'($urandom);
`endif
      end else begin
        req_valid = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
        req_a = $urandom; req_b = $urandom;
`ifdef RCA_SEQ_SUB_EN
        req_sub = 2'($urandom);
`endif
        #1;
        vectors++; if ($countones(req_ready) > 1) begin miscompares++; $display("FAIL rnd_onehot: got %b expected at most one bit", req_ready); end
        if (req_ready != 2'b00) begin
          w  = req_ready[1];
          ew = req_valid[rr] ? rr : ~rr;
          vectors++; if (w !== ew) begin miscompares++; $display("FAIL rnd_grant: got %b expected %b (valid=%b)", w, ew, req_valid); end
          a = req_a[int'(w)*W +: W];
          b = req_b[int'(w)*W +: W];
`ifdef RCA_SEQ_SUB_EN
          s = req_sub[w];
`endif
          esum = s ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
          eid = w; rr = ~w; busy = 1'b1; seen = 1'b0; gcyc = cyc;
        end else begin
          vectors++; if (req_valid !== 2'b00) begin miscompares++; $display("FAIL rnd_no_grant: got ready=00 expected a grant for valid=%b", req_valid); end
        end
      end
    end
    vectors++; if (done < 150) begin miscompares++; $display("FAIL rnd_timeout: got %0d responses expected 150 (SUB_EN=%0d)", done, SUB_EN); end
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1;
    repeat (NNIB + 3) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

`ifdef RCA_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s; logic c, r; int lat; bit ok;
    apply_reset();
    req_sub = 2'b11;
    single_op(0, 16'h0005, 16'h0003, s, c, r, lat, ok);
    vectors++; if (!ok || s !== 16'h0002 || c !== 1'b1) begin
      miscompares++; $display("FAIL sub_pos: got ok=%b sum=%h cout=%b expected 0002/1", ok, s, c);
    end
    ack_rsp();
    single_op(1, 16'h0003, 16'h0005, s, c, r, lat, ok);
    vectors++; if (!ok || s !== 16'hFFFE || c !== 1'b0) begin
      miscompares++; $display("FAIL sub_neg: got ok=%b sum=%h cout=%b expected fffe/0", ok, s, c);
    end
    ack_rsp();
    req_sub = 2'b00;
    single_op(0, 16'h0005, 16'h0003, s, c, r, lat, ok);
    vectors++; if (!ok || s !== 16'h0008 || c !== 1'b0) begin
      miscompares++; $display("FAIL sub_off: got ok=%b sum=%h cout=%b expected 0008/0", ok, s, c);
    end
    ack_rsp();
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
`ifdef RCA_SEQ_SUB_EN
    req_sub = '0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midrun();
    test_arbitration();
`ifdef RCA_SEQ_SUB_EN
    test_sub();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
